// File: rtl/aes_regslice_fifo_if.sv
// Stream bundle for aes_regslice_fifo: upstream valid/ack, downstream valid/ack, and status.
// The slave modport is the FIFO's view; the master modport is the view of whatever drives it.
interface aes_regslice_fifo_if #(
  parameter int DataWidth = 32,
  parameter int Depth     = 4
);
  localparam int CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] data_in;
  logic                 vld_in;
  logic                 ack_in;
  logic [DataWidth-1:0] data_out;
  logic                 vld_out;
  logic                 ack_out;
  logic [CntW-1:0]      count;
  logic                 almost_full;
  logic                 apdone_blk;

  modport slave (
    input  data_in, vld_in, ack_out,
    output ack_in, data_out, vld_out, count, almost_full, apdone_blk
  );

  modport master (
    output data_in, vld_in, ack_out,
    input  ack_in, data_out, vld_out, count, almost_full, apdone_blk
  );
endinterface

// File: rtl/aes_regslice_fifo.sv
// Configurable-depth, fully registered valid/ack FIFO with first-word fall-through,
// occupancy count, almost-full and block-done indication for the AES stream ports.
module aes_regslice_fifo #(
  parameter int DataWidth = 32,
  parameter int Depth     = 4,
  parameter int AfThresh  = 3
) (
  input logic             ap_clk,
  input logic             ap_rst,
  aes_regslice_fifo_if.slave bus
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);
  localparam logic [CntW-1:0] AfC    = CntW'(AfThresh);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("aes_regslice_fifo: Depth must be a power of two >= 2");
  end
  if (AfThresh < 1 || AfThresh > Depth) begin : g_bad_af
    $error("aes_regslice_fifo: AfThresh must lie in 1..Depth");
  end

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count_q;
  logic [CntW-1:0]      count_next;
  logic                 vld_q;
  logic                 ack_q;
  logic                 push;
  logic                 pop;

  assign push = bus.vld_in & ack_q;
  assign pop  = vld_q & bus.ack_out;

  always_comb begin
    count_next = count_q;
    if (push && !pop)      count_next = count_q + 1'b1;
    else if (pop && !push) count_next = count_q - 1'b1;
  end

  // ack_in and vld_out come from count_next through flops, so neither handshake
  // input reaches the opposite handshake output combinationally.
  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (ap_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
      ack_q   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      vld_q   <= (count_next != '0);
      ack_q   <= (count_next != DepthC);
    end
  end

  // NOTE: storage is deliberately left out of reset; stale entries are unreachable once count is 0.
  always_ff @(posedge ap_clk) begin
    if (push && !ap_rst) mem[wr_ptr] <= bus.data_in;
  end

  assign bus.data_out    = mem[rd_ptr];
  assign bus.vld_out     = vld_q;
  assign bus.ack_in      = ack_q;
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AfC);
  assign bus.apdone_blk  = (count_q == DepthC) | (vld_q & ~bus.ack_out);
endmodule

// File: tb/tb_aes_regslice_fifo.sv
// Self-checking bench for aes_regslice_fifo: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_aes_regslice_fifo;
  localparam int DataWidth = 32;
  localparam int Depth     = 4;
  localparam int AfThresh  = 3;
  localparam int CntW      = $clog2(Depth + 1);

  logic ap_clk = 1'b0;
  logic ap_rst;

  aes_regslice_fifo_if #(.DataWidth(DataWidth), .Depth(Depth)) bus ();

  aes_regslice_fifo #(
    .DataWidth(DataWidth),
    .Depth    (Depth),
    .AfThresh (AfThresh)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int                   checks = 0;
  int                   errors = 0;
  int                   pops   = 0;
  bit                   model_ok = 1'b0;
  logic [DataWidth-1:0] q[$];

  task automatic check(input string tag, input logic [DataWidth-1:0] obs,
                       input logic [DataWidth-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare outputs with the model mid-cycle, then advance the model across one rising edge.
  task automatic step();
    bit                   push;
    bit                   pop;
    logic [DataWidth-1:0] d;
    int                   n;
    #1;
    n = q.size();
    if (model_ok) begin
      check("count",       DataWidth'(bus.count),       DataWidth'(n));
      check("vld_out",     DataWidth'(bus.vld_out),     DataWidth'(n != 0));
      check("ack_in",      DataWidth'(bus.ack_in),      DataWidth'(n != Depth));
      check("almost_full", DataWidth'(bus.almost_full), DataWidth'(n >= AfThresh));
      check("apdone_blk",  DataWidth'(bus.apdone_blk),
            DataWidth'((n == Depth) || (n != 0 && !bus.ack_out)));
      if (n != 0) check("data_out", bus.data_out, q[0]);
    end
    push = !ap_rst && bus.vld_in && (n < Depth);
    pop  = !ap_rst && bus.ack_out && (n > 0);
    d    = bus.data_in;
    @(posedge ap_clk);
    if (ap_rst) begin
      q.delete();
      model_ok = 1'b1;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (push) q.push_back(d);
    end
    @(negedge ap_clk);
  endtask

  task automatic drive(input logic v, input logic [DataWidth-1:0] d, input logic a);
    bus.vld_in  = v;
    bus.data_in = d;
    bus.ack_out = a;
  endtask

  initial begin
    int sent;
    int budget;
    int pops0;

    drive(1'b0, '0, 1'b0);
    ap_rst = 1'b1;
    @(negedge ap_clk);

    // Reset then idle
    step();
    step();
    ap_rst = 1'b0;
    #1;
    check("rst_ack_in",      DataWidth'(bus.ack_in),      32'd1);
    check("rst_vld_out",     DataWidth'(bus.vld_out),     32'd0);
    check("rst_count",       DataWidth'(bus.count),       32'd0);
    check("rst_almost_full", DataWidth'(bus.almost_full), 32'd0);
    check("rst_apdone_blk",  DataWidth'(bus.apdone_blk),  32'd0);
    step();

    // Single word: visible the cycle after acceptance, popped, then empty
    drive(1'b1, 32'hA5A5_0001, 1'b1);
    step();
    drive(1'b0, '0, 1'b1);
    #1;
    check("single_vld",  DataWidth'(bus.vld_out), 32'd1);
    check("single_data", bus.data_out,            32'hA5A5_0001);
    step();
    #1;
    check("single_empty", DataWidth'(bus.count), 32'd0);
    step();

    // Fill and block with ack_out low
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + i, 1'b0);
      step();
    end
    drive(1'b1, 32'h14, 1'b0);
    step();
    step();
    #1;
    check("full_count",  DataWidth'(bus.count),       32'd4);
    check("full_ack_in", DataWidth'(bus.ack_in),      32'd0);
    check("full_af",     DataWidth'(bus.almost_full), 32'd1);
    check("full_apdone", DataWidth'(bus.apdone_blk),  32'd1);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      #1;
      check("drain_data", bus.data_out, 32'h10 + i);
      step();
    end
    #1;
    check("drained_vld", DataWidth'(bus.vld_out), 32'd0);
    check("drained_ack", DataWidth'(bus.ack_in),  32'd1);

    // Six more words with random back-pressure so both pointers wrap
    sent   = 0;
    budget = 0;
    while (sent < 6 && budget < 200) begin
      drive(1'b1, 32'h20 + sent, 1'($urandom));
      #1;
      if (bus.ack_in) sent++;
      step();
      budget++;
    end
    check("wrap_sent", DataWidth'(sent), 32'd6);
    budget = 0;
    while (q.size() != 0 && budget < 50) begin
      drive(1'b0, '0, 1'($urandom));
      step();
      budget++;
    end
    check("wrap_drained", DataWidth'(q.size()), 32'd0);

    // Streaming: one word per cycle, no bubbles after the first
    pops0 = pops;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h1000 + i, 1'b1);
      step();
    end
    check("stream_pops", DataWidth'(pops - pops0), 32'd99);
    drive(1'b0, '0, 1'b1);
    step();

    // Reset mid-operation with three words held
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEAD_0000 + i, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    #1;
    check("mrst_count", DataWidth'(bus.count),   32'd0);
    check("mrst_vld",   DataWidth'(bus.vld_out), 32'd0);
    check("mrst_ack",   DataWidth'(bus.ack_in),  32'd1);
    drive(1'b1, 32'h0000_0077, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    #1;
    check("mrst_new_data", bus.data_out, 32'h0000_0077);
    step();
    drive(1'b0, '0, 1'b1);
    step();

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      ap_rst = ($urandom_range(0, 59) == 0);
      drive(1'($urandom), $urandom, 1'($urandom));
      step();
    end
    ap_rst = 1'b0;
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < Depth + 2; i++) step();
    check("final_empty", DataWidth'(bus.count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
